// File: rtl/cluster_pkg.sv
// Shared types and constants for the cluster transmit path.
//   cluster_t  : one 14-bit cluster {cnt[2:0], adr[10:0]}; adr == INVALID_ADR marks an empty slot.
//   out_word_t : one 17-bit output word {bx_tag[2:0], cluster}.
package cluster_pkg;

  localparam int CLUSTER_W = 14;
  localparam int ADR_W     = 11;
  localparam int CNT_W     = 3;
  localparam int BX_W      = 12;
  localparam int TAG_W     = 3;
  localparam int NUM_CL    = 8;
  localparam int OUT_W     = TAG_W + CLUSTER_W;

  localparam logic [ADR_W-1:0] INVALID_ADR = 11'h7FF;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [ADR_W-1:0] adr;
  } cluster_t;

  typedef struct packed {
    logic [TAG_W-1:0] bx_tag;
    cluster_t         cluster;
  } out_word_t;

endpackage

// File: rtl/cluster_tx_scheduler_if.sv
// Output stream of the cluster scheduler toward the link serializer.
//   out_data  : buffered word {bx_tag, cnt, adr}
//   out_valid : out_data holds a buffered word
//   out_ready : consumer can take a word this cycle
// Handshake: a word moves on every clock edge where out_valid and out_ready
// are both high. While out_valid is high and out_ready is low, the source
// keeps out_valid high and out_data unchanged. out_valid never depends on
// out_ready.
interface cluster_tx_scheduler_if;
  import cluster_pkg::*;

  out_word_t out_data;
  logic      out_valid;
  logic      out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/cluster_fifo_2w1r.sv
// Circular buffer with two write ports and one first-word-fall-through read port.
//   clk, rst_n   : clock, synchronous active-low reset
//   we0/wd0      : write port 0 (lands at the write pointer)
//   we1/wd1      : write port 1 (lands after port 0 when both are used)
//   re           : pop the head; ignored when empty
//   rd_data      : head word, 0 when empty
//   rd_valid     : buffer not empty
//   count/free   : stored entries / empty entries
// The writer must not exceed 'free'; the buffer does not guard against it.
module cluster_fifo_2w1r
  import cluster_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we0,
  input  out_word_t     wd0,
  input  logic          we1,
  input  out_word_t     wd1,
  input  logic          re,
  output out_word_t     rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] count,
  output logic [CW-1:0] free
);

  out_word_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] addr1;
  logic          pop;

  assign rd_valid = (count != '0);
  assign pop      = re & rd_valid;
  assign free     = CW'(DEPTH) - count;
  // Gating keeps stale memory contents off the bus when empty.
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign addr1    = we0 ? wr_ptr + AW'(1) : wr_ptr;

  always_ff @(posedge clk) begin
    if (we0) mem[wr_ptr] <= wd0;
    if (we1) mem[addr1]  <= wd1;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(we0) + AW'(we1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + CW'(we0) + CW'(we1) - CW'(pop);
    end
  end

endmodule

// File: rtl/cluster_tx_scheduler.sv
// Serialises the eight per-BX clusters onto a one-cluster-per-cycle stream.
//   clock4x, global_reset_n : 160 MHz clock, synchronous active-low reset
//   enable                  : 0 ignores in_valid; buffered data still drains
//   bc0, in_valid           : BX-zero marker and new-snapshot strobe
//   cluster0..cluster7      : snapshot, adr == 0x7FF means no cluster
//   tx                      : output stream (out_data/out_valid/out_ready)
//   occupancy               : buffered entries
//   bx_cnt                  : current BX number
//   drop_cnt, overflow      : saturating lost-cluster count, sticky drop flag
// A snapshot is staged, then the two lowest pending clusters per cycle are
// written into the buffer. A new snapshot arriving before staging empties
// discards whatever is still pending after that cycle's writes.
module cluster_tx_scheduler
  import cluster_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int BX_MAX = 3563,
  parameter int DROP_W = 16
) (
  input  logic                     clock4x,
  input  logic                     global_reset_n,
  input  logic                     enable,
  input  logic                     bc0,
  input  logic                     in_valid,
  input  logic [CLUSTER_W-1:0]     cluster0,
  input  logic [CLUSTER_W-1:0]     cluster1,
  input  logic [CLUSTER_W-1:0]     cluster2,
  input  logic [CLUSTER_W-1:0]     cluster3,
  input  logic [CLUSTER_W-1:0]     cluster4,
  input  logic [CLUSTER_W-1:0]     cluster5,
  input  logic [CLUSTER_W-1:0]     cluster6,
  input  logic [CLUSTER_W-1:0]     cluster7,
  cluster_tx_scheduler_if.master   tx,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [BX_W-1:0]          bx_cnt,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  cluster_t           in_cl [NUM_CL];
  cluster_t           stage [NUM_CL];
  logic [NUM_CL-1:0]  pending;
  logic [NUM_CL-1:0]  in_mask;
  logic [NUM_CL-1:0]  clr_mask;
  logic [NUM_CL-1:0]  left;
  logic [TAG_W-1:0]   stage_tag;
  logic               accept;
  logic [BX_W-1:0]    bx_next;
  logic               has0, has1;
  logic [2:0]         idx0, idx1;
  logic               we0, we1;
  out_word_t          wd0, wd1;
  logic [CW-1:0]      free;
  logic [3:0]         left_cnt;
  logic [DROP_W:0]    drop_sum;
  logic [DROP_W-1:0]  drop_next;

  assign accept = in_valid & enable;

  always_comb begin
    in_cl[0] = cluster_t'(cluster0);
    in_cl[1] = cluster_t'(cluster1);
    in_cl[2] = cluster_t'(cluster2);
    in_cl[3] = cluster_t'(cluster3);
    in_cl[4] = cluster_t'(cluster4);
    in_cl[5] = cluster_t'(cluster5);
    in_cl[6] = cluster_t'(cluster6);
    in_cl[7] = cluster_t'(cluster7);
    for (int i = 0; i < NUM_CL; i++) in_mask[i] = (in_cl[i].adr != INVALID_ADR);
  end

  always_comb begin
    if (bc0)                            bx_next = '0;
    else if (bx_cnt == BX_W'(BX_MAX))   bx_next = '0;
    else                                bx_next = bx_cnt + BX_W'(1);
  end

  // Two-lowest-set-bit picker over the pending mask.
  always_comb begin
    has0 = 1'b0;
    has1 = 1'b0;
    idx0 = '0;
    idx1 = '0;
    for (int i = 0; i < NUM_CL; i++) begin
      if (pending[i]) begin
        if (!has0) begin
          has0 = 1'b1;
          idx0 = 3'(i);
        end else if (!has1) begin
          has1 = 1'b1;
          idx1 = 3'(i);
        end
      end
    end
  end

  // Space is judged on the start-of-cycle count; a pop this cycle does not help.
  assign we0 = has0 && (free != '0);
  assign we1 = has1 && (free > CW'(1));
  assign wd0 = {stage_tag, stage[idx0]};
  assign wd1 = {stage_tag, stage[idx1]};

  always_comb begin
    clr_mask = '0;
    if (we0) clr_mask[idx0] = 1'b1;
    if (we1) clr_mask[idx1] = 1'b1;
    left     = pending & ~clr_mask;
    left_cnt = '0;
    for (int i = 0; i < NUM_CL; i++) left_cnt = left_cnt + 4'(left[i]);
  end

  assign drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(left_cnt);
  assign drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      pending   <= '0;
      stage_tag <= '0;
      bx_cnt    <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < NUM_CL; i++) stage[i] <= '0;
    end else if (accept) begin
      // Whatever this cycle's writes leave behind is lost to the new snapshot.
      if (left != '0) begin
        drop_cnt <= drop_next;
        overflow <= 1'b1;
      end
      pending   <= in_mask;
      stage_tag <= bx_next[TAG_W-1:0];
      bx_cnt    <= bx_next;
      for (int i = 0; i < NUM_CL; i++) stage[i] <= in_cl[i];
    end else begin
      pending <= left;
    end
  end

  cluster_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clock4x),
    .rst_n    (global_reset_n),
    .we0      (we0),
    .wd0      (wd0),
    .we1      (we1),
    .wd1      (wd1),
    .re       (tx.out_ready),
    .rd_data  (tx.out_data),
    .rd_valid (tx.out_valid),
    .count    (occupancy),
    .free     (free)
  );

endmodule

// File: tb/tb_cluster_tx_scheduler.sv
module tb_cluster_tx_scheduler;
  import cluster_pkg::*;

  localparam int DEPTH  = 32;
  localparam int BX_MAX = 3563;
  localparam int DROP_W = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clock4x = 1'b0;
  logic        global_reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        bc0 = 1'b0;
  logic        in_valid = 1'b0;
  logic [13:0] cl [8];
  logic [5:0]  occupancy;
  logic [11:0] bx_cnt;
  logic [15:0] drop_cnt;
  logic        overflow;

  always #5 clock4x = ~clock4x;

  cluster_tx_scheduler_if tx();

  cluster_tx_scheduler #(.DEPTH(DEPTH), .BX_MAX(BX_MAX), .DROP_W(DROP_W)) dut (
    .clock4x        (clock4x),
    .global_reset_n (global_reset_n),
    .enable         (enable),
    .bc0            (bc0),
    .in_valid       (in_valid),
    .cluster0       (cl[0]),
    .cluster1       (cl[1]),
    .cluster2       (cl[2]),
    .cluster3       (cl[3]),
    .cluster4       (cl[4]),
    .cluster5       (cl[5]),
    .cluster6       (cl[6]),
    .cluster7       (cl[7]),
    .tx             (tx),
    .occupancy      (occupancy),
    .bx_cnt         (bx_cnt),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_pass = 0;
  int          n_total = 0;
  logic [16:0] exp_q [$];   // words expected in the buffer, head first
  logic [16:0] pend_q [$];  // staged clusters not yet buffered, index order
  int          m_bx = 0;
  int          m_drop = 0;
  bit          m_ovf = 1'b0;
  bit          checking = 1'b0;
  int          pops = 0;
  logic [2:0]  pop_tags [$];
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [16:0] prev_data = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
  endtask

  // One clock edge of the specified behaviour, using the inputs now driven.
  task automatic model_edge();
    int          freen;
    int          n;
    int          nb;
    logic [16:0] w;
    if (!global_reset_n) begin
      exp_q.delete();
      pend_q.delete();
      m_bx = 0;
      m_drop = 0;
      m_ovf = 1'b0;
      return;
    end
    freen = DEPTH - exp_q.size();
    if (tx.out_ready && exp_q.size() != 0) w = exp_q.pop_front();
    n = 2;
    if (freen < n) n = freen;
    if (pend_q.size() < n) n = pend_q.size();
    repeat (n) exp_q.push_back(pend_q.pop_front());
    if (in_valid && enable) begin
      if (pend_q.size() != 0) begin
        m_ovf = 1'b1;
        m_drop = m_drop + pend_q.size();
        if (m_drop > 65535) m_drop = 65535;
      end
      nb = bc0 ? 0 : ((m_bx == BX_MAX) ? 0 : m_bx + 1);
      m_bx = nb;
      pend_q.delete();
      for (int i = 0; i < 8; i++)
        if (cl[i][10:0] != 11'h7FF) pend_q.push_back({3'(nb), cl[i]});
    end
  endtask

  // Compare outputs against the model, then advance one clock.
  task automatic cycle();
    if (checking) begin
      check("occupancy", occupancy, exp_q.size());
      check("out_valid", tx.out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("out_data", tx.out_data, exp_q[0]);
      check("bx_cnt", bx_cnt, m_bx);
      check("drop_cnt", drop_cnt, m_drop);
      check("overflow", overflow, m_ovf);
      if (prev_valid && !prev_ready && tx.out_valid) check("hold_stable", tx.out_data, prev_data);
    end
    if (tx.out_valid === 1'b1 && tx.out_ready === 1'b1) begin
      pops++;
      pop_tags.push_back(tx.out_data[16:14]);
    end
    prev_valid = tx.out_valid;
    prev_ready = tx.out_ready;
    prev_data  = tx.out_data;
    model_edge();
    @(posedge clock4x);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cl(logic [7:0] mask, int salt);
    for (int i = 0; i < 8; i++)
      cl[i] = mask[i] ? {3'(i + salt), 11'(i * 64 + salt)} : {3'(salt), 11'h7FF};
  endtask

  task automatic do_reset();
    global_reset_n = 1'b0;
    in_valid = 1'b0;
    cycle();
    global_reset_n = 1'b1;
  endtask

  task automatic drain(string name);
    tx.out_ready = 1'b1;
    for (int k = 0; k < 200 && occupancy != 0; k++) cycle();
    check(name, occupancy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         en;
    bit         bc;
    logic [7:0] mask;
    int         exp_bx;
    int         exp_n;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int gap;
    vecs[0] = '{en: 1'b1, bc: 1'b0, mask: 8'hFF, exp_bx: 2, exp_n: 8};
    vecs[1] = '{en: 1'b0, bc: 1'b0, mask: 8'hFF, exp_bx: 2, exp_n: 0};
    vecs[2] = '{en: 1'b1, bc: 1'b1, mask: 8'h80, exp_bx: 0, exp_n: 1};
    vecs[3] = '{en: 1'b1, bc: 1'b0, mask: 8'h00, exp_bx: 1, exp_n: 0};
    vecs[4] = '{en: 1'b1, bc: 1'b0, mask: 8'h5A, exp_bx: 2, exp_n: 4};
    vecs[5] = '{en: 1'b1, bc: 1'b0, mask: 8'h01, exp_bx: 3, exp_n: 1};

    set_cl(8'h00, 0);
    tx.out_ready = 1'b0;
    cycle();
    cycle();
    global_reset_n = 1'b1;
    checking = 1'b1;
    check("rst_occ", occupancy, 0);
    check("rst_valid", tx.out_valid, 0);
    check("rst_data", tx.out_data, 0);
    check("rst_bx", bx_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ovf", overflow, 0);
    enable = 1'b1;

    // Single BX, clusters 0 and 5 valid.
    tx.out_ready = 1'b1;
    set_cl(8'h00, 0);
    cl[0] = {3'd3, 11'h010};
    cl[5] = {3'd0, 11'h5FF};
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    set_cl(8'h00, 0);
    check("single_t1_valid", tx.out_valid, 0);
    cycle();
    check("single_t2_valid", tx.out_valid, 1);
    check("single_t2_data", tx.out_data, {3'd1, 3'd3, 11'h010});
    cycle();
    check("single_t3_valid", tx.out_valid, 1);
    check("single_t3_data", tx.out_data, {3'd1, 3'd0, 11'h5FF});
    cycle();
    check("single_empty", tx.out_valid, 0);
    check("single_bx", bx_cnt, 1);
    check("single_drop", drop_cnt, 0);

    // Table vectors, each drained with out_ready high.
    foreach (vecs[v]) begin
      set_cl(vecs[v].mask, v + 1);
      enable = vecs[v].en;
      bc0 = vecs[v].bc;
      in_valid = 1'b1;
      pops = 0;
      pop_tags.delete();
      cycle();
      in_valid = 1'b0;
      bc0 = 1'b0;
      enable = 1'b1;
      repeat (11) cycle();
      check("vec_bx", bx_cnt, vecs[v].exp_bx);
      check("vec_pops", pops, vecs[v].exp_n);
      foreach (pop_tags[k]) check("vec_tag", pop_tags[k], 3'(vecs[v].exp_bx));
    end

    // Full BX rate, all 8 valid, consumer stalled.
    do_reset();
    tx.out_ready = 1'b0;
    for (int b = 0; b < 10; b++) begin
      set_cl(8'hFF, b);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (3) cycle();
    end
    check("full_occ", occupancy, 32);
    check("full_drop", drop_cnt, 40);
    check("full_ovf", overflow, 1);
    check("full_bx", bx_cnt, 10);
    drain("full_drain");

    // Reset two cycles after a full snapshot.
    set_cl(8'hFF, 7);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    global_reset_n = 1'b0;
    cycle();
    global_reset_n = 1'b1;
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_valid", tx.out_valid, 0);
    check("mid_rst_bx", bx_cnt, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_ovf", overflow, 0);
    for (int k = 0; k < 10; k++) begin
      check("mid_rst_no_stale", tx.out_valid, 0);
      cycle();
    end

    // Enable low: strobes ignored, existing entries drain.
    tx.out_ready = 1'b0;
    set_cl(8'hFF, 3);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();
    check("en_occ_loaded", occupancy, 8);
    enable = 1'b0;
    in_valid = 1'b1;
    repeat (3) cycle();
    in_valid = 1'b0;
    enable = 1'b1;
    check("en_occ_held", occupancy, 8);
    check("en_bx_held", bx_cnt, 1);
    tx.out_ready = 1'b1;
    repeat (10) cycle();
    check("en_drained", occupancy, 0);

    // BX wrap and bc0.
    do_reset();
    set_cl(8'h00, 0);
    in_valid = 1'b1;
    repeat (3563) cycle();
    check("wrap_max", bx_cnt, 3563);
    cycle();
    check("wrap_zero", bx_cnt, 0);
    repeat (100) cycle();
    check("bc0_pre", bx_cnt, 100);
    bc0 = 1'b1;
    set_cl(8'h04, 9);
    cycle();
    bc0 = 1'b0;
    in_valid = 1'b0;
    set_cl(8'h00, 0);
    check("bc0_bx", bx_cnt, 0);
    cycle();
    check("bc0_valid", tx.out_valid, 1);
    check("bc0_tag", tx.out_data[16:14], 0);
    drain("bc0_drain");

    // Randomized traffic with random backpressure; model checks every cycle.
    do_reset();
    gap = 2;
    for (int c = 0; c < 1600; c++) begin
      tx.out_ready = (c < 800) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      in_valid = 1'b0;
      if (gap == 0) begin
        in_valid = 1'b1;
        enable = ($urandom_range(0, 9) != 0);
        bc0 = ($urandom_range(0, 19) == 0);
        for (int i = 0; i < 8; i++) begin
          cl[i] = 14'($urandom_range(0, 16383));
          if ($urandom_range(0, 1) == 1) cl[i][10:0] = 11'h7FF;
        end
        gap = $urandom_range(2, 9);
      end else begin
        gap--;
      end
      cycle();
      enable = 1'b1;
      bc0 = 1'b0;
    end
    in_valid = 1'b0;
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cluster_tx_scheduler.md
# cluster_tx_scheduler

Sequences the eight 14-bit clusters produced by `cluster_packer` each bunch crossing onto a single cluster-per-cycle output stream toward the trigger link serializer. Each BX snapshot is latched, and valid clusters are compacted two per cycle into a 2-write/1-read buffer. The buffer is drained with a valid/ready handshake, and every cluster is tagged with its BX. The block also maintains the BX counter and overflow bookkeeping for the link.

## Interface
Parameters:
- `DEPTH`, 32: buffer entries; power of two, ≥ 4.
- `BX_MAX`, 3563: last BX number before wrap.
- `DROP_W`, 16: drop-counter width.

Ports (the reset is synchronous and active-low):
- `clock4x`  in  1  sole clock, 160 MHz.
- `global_reset_n`  in  1  synchronous reset, active-low.
- `enable`  in  1  0: ignore `in_valid`; the buffer still drains.
- `bc0`  in  1  BX-zero marker, sampled with `in_valid`.
- `in_valid`  in  1  one-cycle strobe: `cluster0..7` hold a new BX snapshot.
- `cluster0`..`cluster7`  in  14 each  {cnt[13:11], adr[10:0]}; `adr` = 0x7FF means invalid.
- `out_data`  out  17  {bx_tag[2:0], cnt[2:0], adr[10:0]}.
- `out_valid`  out  1  `out_data` holds a buffered cluster.
- `out_ready`  in  1  consumer accepts when high together with `out_valid`.
- `occupancy`  out  $clog2(DEPTH)+1  buffered entries.
- `bx_cnt`  out  12  current BX number.
- `drop_cnt`  out  DROP_W  clusters lost; saturates at all-ones.
- `overflow`  out  1  sticky; set on any drop.

## Operation
- **Snapshot.** On `in_valid & enable`, the block latches the 8 clusters into the staging register.
  - `pending[7:0]` is set from `adr != 0x7FF`.
  - The snapshot's tag is bx_tag = next BX value[2:0].
- **BX counter.**
  - Advances on every accepted `in_valid`: 0 if `bc0`, else 0 if at `BX_MAX`, else +1.
  - Unchanged otherwise.
- **Compaction.**
  - Each cycle, pick the two lowest-index set bits of `pending`.
  - Write them to the buffer in index order (lower index first), then clear them from `pending`.
  - One pick → one write. Zero picks → idle.
  - A snapshot fully drains in ≤ 4 cycles.
- **Space check.**
  - `free = DEPTH - occupancy` is taken at the start of the cycle; a pop in the same cycle does not add space.
  - free = 1: only the lower pick is written; the other stays pending.
  - free = 0: nothing is written; all stay pending (stall).
- **Overrun.**
  - Occurs on an accepted `in_valid` while `pending != 0`.
  - The leftover pending clusters are discarded, with `drop_cnt += popcount(pending)` (saturating) and `overflow` set.
  - The new snapshot is then loaded the same cycle.
- **Output.**
  - `out_valid = occupancy != 0`. `out_data` is the buffer head, held stable while `out_valid & !out_ready`.
  - The head is popped when `out_valid & out_ready`.
- **Order.** Clusters leave in BX order, and in ascending cluster index within a BX.
- **Enable low.** `enable` low does not abort a staging drain already in progress.

## Timing
- `in_valid` at cycle t → staging and `pending` valid in cycle t+1 → first writes at the end of t+1 → `out_valid` high in t+2 (empty buffer).
- Output is registered-head FWFT: `out_data` is valid in the same cycle as `out_valid`.
- Simultaneous write(s) and pop: `occupancy` = old + writes − pop.
- Pointers wrap modulo `DEPTH`; the write pointer advances by 0, 1 or 2.
- Reset (the synchronous `global_reset_n` = 0), including mid-drain, clears:
  - the pointers, `pending` and staging;
  - `occupancy`, `bx_cnt`, `drop_cnt` and `overflow`, all to 0;
  - `out_valid`, to 0.
  - `out_data` reads 0 under reset.
- Inputs are ignored during reset.

## Structure
- **`cluster_pkg`** holds:
  - `CLUSTER_W` = 14, `ADR_W` = 11, `CNT_W` = 3;
  - `INVALID_ADR` = 11'h7FF, `BX_W` = 12;
  - a packed cluster typedef {cnt, adr};
  - the out-word typedef {bx_tag, cluster}.
- **`cluster_fifo_2w1r`** is the single sub-module. It is a circular buffer with:
  - 2 write ports, `we0`/`we1`;
  - a FWFT read port;
  - `count` and `free` outputs.
- **Top level** holds the staging register, the two-lowest-set-bit picker, the BX counter and the drop logic.

## Test plan
- **Single BX, two valid clusters.** Cluster0 = {3, 0x010} and cluster5 = {0, 0x5FF}, others 0x7FF; `in_valid` at t, `out_ready` = 1.
  - Expect `out_valid` at t+2 with {tag 1, 3, 0x010}, then at t+3 with {tag 1, 0, 0x5FF}.
  - `bx_cnt` = 1; `drop_cnt` = 0.
- **Full BX rate, all 8 valid.** `in_valid` every 4th cycle for 10 BX, `out_ready` = 0.
  - The buffer fills to 32 mid BX4, then stalls.
  - The next `in_valid` drops the leftovers (popcount counted), so `drop_cnt` is nonzero and `overflow` = 1.
  - Entries after release are in order.
- **Backpressure hold.** Toggle `out_ready` pseudo-randomly.
  - `out_data` is stable while `out_valid & !out_ready`.
  - A scoreboard sees no loss and no reorder when the input load is ≤ 1 cluster/cycle.
- **BX wrap and bc0.**
  - 3564 strobes → `bx_cnt` reaches 3563, then 0.
  - `bc0` with `in_valid` at `bx_cnt` = 100 → `bx_cnt` = 0; tag = 0.
- **Reset mid-drain.** Load 8 valid clusters, then assert `global_reset_n` = 0 at t+2 for one cycle.
  - All counters are 0, `out_valid` = 0, and no stale cluster emerges afterwards.
- **Enable low.** `enable` = 0 with `in_valid` pulses.
  - `bx_cnt` is unchanged and no writes occur; existing entries still drain.
